// File: rtl/fir_ppg_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module      : fir_ppg_scheduler_if
// Description : Bus bundle between the PPG scheduler and its ADC / shared FIR
//               neighbours.
//               master : the scheduler (drives ADC_Start and the FIR controls)
//               slave  : the ADC + FIR side (drives ADC_Done/Value, Fir_Dout)
// Signals     : ADC_Start  one-cycle conversion request
//               ADC_Done   one-cycle conversion complete strobe
//               ADC_Value  sample, valid with ADC_Done
//               Fir_Ch_Sel FIR bank select (0 = RED, 1 = IR)
//               Fir_Din    sample presented to the FIR
//               Fir_En     one-hot phase enable (shift / multiply / add)
//               Fir_Dout   FIR result
// Revision    : 1.0  initial release
// ============================================================================
interface fir_ppg_scheduler_if #(
    parameter int DW = 8,
    parameter int OW = 20
);
    logic          ADC_Start;
    logic          ADC_Done;
    logic [DW-1:0] ADC_Value;
    logic          Fir_Ch_Sel;
    logic [DW-1:0] Fir_Din;
    logic [2:0]    Fir_En;
    logic [OW-1:0] Fir_Dout;

    modport master (
        output ADC_Start, Fir_Ch_Sel, Fir_Din, Fir_En,
        input  ADC_Done, ADC_Value, Fir_Dout
    );

    modport slave (
        input  ADC_Start, Fir_Ch_Sel, Fir_Din, Fir_En,
        output ADC_Done, ADC_Value, Fir_Dout
    );
endinterface
`default_nettype wire

// File: rtl/fir_ppg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : fir_ppg_scheduler
// Description : Pulse-oximeter front-end sequencer. Alternates the LED between
//               RED and IR, requests an ADC conversion a settle time after each
//               toggle, buffers one sample per channel and time-shares a single
//               3-phase FIR between the two channels (round-robin).
// Ports       : CLK_Filter       clock, rising edge
//               rst              synchronous active-high reset
//               Enable           run control (freezes LED timing when low)
//               LED_Sel          0 = RED LED on, 1 = IR LED on
//               bus              ADC / FIR bundle (master side)
//               Out_RED_Filtered last RED result
//               Out_IR_Filtered  last IR result
//               RED_Valid        one-cycle pulse on RED update
//               IR_Valid         one-cycle pulse on IR update
//               Overrun          sticky: a pending sample was overwritten
// Revision    : 1.0  initial release
// ============================================================================
module fir_ppg_scheduler #(
    parameter int HALF_PERIOD = 500,
    parameter int SETTLE      = 50,
    parameter int DW          = 8,
    parameter int OW          = 20
) (
    input  wire logic            CLK_Filter,
    input  wire logic            rst,
    input  wire logic            Enable,
    output logic                 LED_Sel,
    fir_ppg_scheduler_if.master  bus,
    output logic [OW-1:0]        Out_RED_Filtered,
    output logic [OW-1:0]        Out_IR_Filtered,
    output logic                 RED_Valid,
    output logic                 IR_Valid,
    output logic                 Overrun
);
    localparam int             c_CW     = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
    localparam logic [c_CW-1:0] c_LAST   = c_CW'(HALF_PERIOD - 1);
    localparam logic [c_CW-1:0] c_SETTLE = c_CW'(SETTLE);

    localparam logic [2:0] c_IDLE = 3'd0;
    localparam logic [2:0] c_PH0  = 3'd1;
    localparam logic [2:0] c_PH1  = 3'd2;
    localparam logic [2:0] c_PH2  = 3'd3;
    localparam logic [2:0] c_CAP  = 3'd4;

    logic [c_CW-1:0] r_count;
    logic            r_led;
    logic            r_req_v;
    logic            r_req_ch;
    logic [1:0]      r_pend;
    logic [DW-1:0]   r_slot [2];
    logic            r_last;
    logic            r_ovr;
    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic            r_ch;
    logic [DW-1:0]   r_din;
    logic [OW-1:0]   r_out_red;
    logic [OW-1:0]   r_out_ir;

    logic            w_wrap;
    logic            w_start;
    logic            w_capture;
    logic            w_dispatch;
    logic            w_sel;
    logic            w_overwrite;
    logic [1:0]      w_pend_nxt;
    logic [2:0]      w_fir_en;
    logic            w_cap;

    // ------------------------------------------------------------------
    // LED phase timing
    // ------------------------------------------------------------------
    assign w_wrap  = Enable && (r_count == c_LAST);
    assign w_start = Enable && !rst && (r_count == c_SETTLE);

    always_ff @(posedge CLK_Filter) begin
        if (rst) begin
            r_count <= '0;
            r_led   <= 1'b0;
        end else if (Enable) begin
            if (w_wrap) begin
                r_count <= '0;
                r_led   <= ~r_led;
            end else begin
                r_count <= r_count + c_CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Conversion request: remembers which LED was lit when the ADC was
    // started; an LED toggle before the conversion returns drops it.
    // ------------------------------------------------------------------
    assign w_capture = bus.ADC_Done && r_req_v;

    always_ff @(posedge CLK_Filter) begin
        if (rst) begin
            r_req_v  <= 1'b0;
            r_req_ch <= 1'b0;
        end else if (w_start) begin
            r_req_v  <= 1'b1;
            r_req_ch <= r_led;
        end else if (w_capture || w_wrap) begin
            r_req_v  <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Pending slots. Dispatch clears first, then a same-cycle capture sets
    // the flag again, so the fresh sample is never lost. Overrun only when
    // a sample still waiting (not taken this cycle) is replaced.
    // ------------------------------------------------------------------
    assign w_dispatch = (r_state == c_IDLE) && (|r_pend);
    assign w_sel      = (r_pend == 2'b11) ? ~r_last : r_pend[1];

    always_comb begin
        w_pend_nxt = r_pend;
        if (w_dispatch) w_pend_nxt[w_sel]    = 1'b0;
        if (w_capture)  w_pend_nxt[r_req_ch] = 1'b1;
    end

    assign w_overwrite = w_capture && r_pend[r_req_ch] &&
                         !(w_dispatch && (w_sel == r_req_ch));

    always_ff @(posedge CLK_Filter) begin
        if (rst) begin
            r_pend    <= 2'b00;
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_ovr     <= 1'b0;
        end else begin
            r_pend <= w_pend_nxt;
            if (w_capture)   r_slot[r_req_ch] <= bus.ADC_Value;
            if (w_overwrite) r_ovr            <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Job FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK_Filter) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Job FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (|r_pend) w_state_nxt = c_PH0;
            c_PH0:   w_state_nxt = c_PH1;
            c_PH1:   w_state_nxt = c_PH2;
            c_PH2:   w_state_nxt = c_CAP;
            c_CAP:   w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // Job FSM: outputs
    always_comb begin
        w_fir_en = 3'b000;
        w_cap    = 1'b0;
        case (r_state)
            c_PH0:   w_fir_en = 3'b001;
            c_PH1:   w_fir_en = 3'b010;
            c_PH2:   w_fir_en = 3'b100;
            c_CAP:   w_cap    = 1'b1;
            default: w_fir_en = 3'b000;
        endcase
    end

    // Job datapath: channel/sample held from PH0 through CAP
    always_ff @(posedge CLK_Filter) begin
        if (rst) begin
            r_ch      <= 1'b0;
            r_din     <= '0;
            r_last    <= 1'b1;
            r_out_red <= '0;
            r_out_ir  <= '0;
        end else begin
            if (w_dispatch) begin
                r_ch  <= w_sel;
                r_din <= r_slot[w_sel];
            end
            if (w_cap) begin
                r_last <= r_ch;
                if (r_ch) r_out_ir  <= bus.Fir_Dout;
                else      r_out_red <= bus.Fir_Dout;
            end
        end
    end

    // Valid is shown in the CAP cycle itself with Fir_Dout passed straight
    // through, giving 5 cycles from ADC_Done; a reset in CAP suppresses it.
    assign RED_Valid        = w_cap && !rst && !r_ch;
    assign IR_Valid         = w_cap && !rst &&  r_ch;
    assign Out_RED_Filtered = RED_Valid ? bus.Fir_Dout : r_out_red;
    assign Out_IR_Filtered  = IR_Valid  ? bus.Fir_Dout : r_out_ir;

    assign LED_Sel        = r_led;
    assign Overrun        = r_ovr;
    assign bus.ADC_Start  = w_start;
    assign bus.Fir_En     = w_fir_en;
    assign bus.Fir_Ch_Sel = r_ch;
    assign bus.Fir_Din    = r_din;
endmodule
`default_nettype wire

// File: tb/tb_fir_ppg_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_ppg_scheduler
// Description : Randomised self-checking bench for fir_ppg_scheduler with a
//               queue scoreboard and an independent monitor process.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fir_ppg_scheduler;
    localparam int HP = 4;
    localparam int ST = 1;
    localparam int DW = 8;
    localparam int OW = 20;
    localparam int N_ITER = 1600;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          led;
    logic [OW-1:0] out_red;
    logic [OW-1:0] out_ir;
    logic          red_v;
    logic          ir_v;
    logic          ovr;

    fir_ppg_scheduler_if #(.DW(DW), .OW(OW)) bus ();

    fir_ppg_scheduler #(.HALF_PERIOD(HP), .SETTLE(ST), .DW(DW), .OW(OW)) u_dut (
        .CLK_Filter       (clk),
        .rst              (rst),
        .Enable           (en),
        .LED_Sel          (led),
        .bus              (bus.master),
        .Out_RED_Filtered (out_red),
        .Out_IR_Filtered  (out_ir),
        .RED_Valid        (red_v),
        .IR_Valid         (ir_v),
        .Overrun          (ovr)
    );

    always #5 clk = ~clk;

    // Stand-in FIR: result identifies the channel and the sample it was given
    function automatic logic [OW-1:0] fir_fn(input logic ch, input logic [DW-1:0] d);
        return {(ch ? 4'hA : 4'h5), d, d ^ 8'h3C};
    endfunction

    assign bus.Fir_Dout = fir_fn(bus.Fir_Ch_Sel, bus.Fir_Din);

    typedef struct {
        logic          ch;
        logic [OW-1:0] val;
        int            due;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: pops an expected result whenever a valid pulse appears
    // ------------------------------------------------------------------
    always @(negedge clk) begin
        if (red_v === 1'b1 || ir_v === 1'b1) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_valid cyc=%0d got red=%b ir=%b want none", cyc, red_v, ir_v);
            end else begin
                e = q.pop_front();
                chk("valid_ch",   {30'd0, red_v, ir_v}, e.ch ? 32'd1 : 32'd2);
                chk("valid_due",  cyc, e.due);
                chk("valid_data", e.ch ? {12'd0, out_ir} : {12'd0, out_red}, {12'd0, e.val});
            end
        end
    end

    // ------------------------------------------------------------------
    // Reference model (enabled-cycle arithmetic + slot/timer abstraction)
    // ------------------------------------------------------------------
    int            en_cnt;
    logic          req_v, req_ch;
    logic [1:0]    pend;
    logic [DW-1:0] slot [2];
    logic          last, m_ovr;
    int            busy_until;
    logic          has_job, job_ch;
    logic [DW-1:0] job_din;
    int            job_dc;
    logic [OW-1:0] m_out [2];
    logic          fresh;

    int            done_due;
    logic          want_mid, r_now, st, cap_now, dsel;
    int            k;
    logic [2:0]    exp_en;

    task automatic model_reset();
        en_cnt     = 0;
        req_v      = 1'b0;
        req_ch     = 1'b0;
        pend       = 2'b00;
        slot[0]    = '0;
        slot[1]    = '0;
        last       = 1'b1;
        m_ovr      = 1'b0;
        busy_until = 0;
        has_job    = 1'b0;
        job_ch     = 1'b0;
        job_din    = '0;
        job_dc     = 0;
        m_out[0]   = '0;
        m_out[1]   = '0;
        fresh      = 1'b1;
    endtask

    initial begin
        rst           = 1'b1;
        en            = 1'b0;
        bus.ADC_Done  = 1'b0;
        bus.ADC_Value = '0;
        done_due      = -1;
        want_mid      = 1'b0;
        model_reset();

        for (int it = 0; it < N_ITER; it++) begin
            @(negedge clk);

            // ---- checks on registered state ----
            k       = has_job ? (cyc - job_dc) : 0;
            exp_en  = (k == 1) ? 3'b001 : (k == 2) ? 3'b010 : (k == 3) ? 3'b100 : 3'b000;
            cap_now = has_job && (cyc == job_dc + 4);
            chk("LED_Sel", {31'd0, led}, ((en_cnt / HP) % 2));
            chk("Fir_En",  {29'd0, bus.Fir_En}, {29'd0, exp_en});
            chk("Overrun", {31'd0, ovr}, {31'd0, m_ovr});
            if (!(cap_now && !job_ch)) chk("Out_RED", {12'd0, out_red}, {12'd0, m_out[0]});
            if (!(cap_now &&  job_ch)) chk("Out_IR",  {12'd0, out_ir},  {12'd0, m_out[1]});
            if (has_job && k >= 1 && k <= 4) begin
                chk("Fir_Ch_Sel", {31'd0, bus.Fir_Ch_Sel}, {31'd0, job_ch});
                chk("Fir_Din",    {24'd0, bus.Fir_Din},    {24'd0, job_din});
            end
            if (fresh) begin
                chk("Fir_Din_rst",    {24'd0, bus.Fir_Din},    32'd0);
                chk("Fir_Ch_Sel_rst", {31'd0, bus.Fir_Ch_Sel}, 32'd0);
            end

            // ---- drive inputs for this cycle ----
            if (it == 800) want_mid = 1'b1;
            r_now = (it < 3) || (want_mid && has_job && (cyc == job_dc + 2));
            if (r_now && it >= 3) want_mid = 1'b0;
            rst = r_now;
            if (it < 23 || it >= N_ITER - 30) en = 1'b0;
            else                              en = ($urandom_range(0, 9) != 0);
            bus.ADC_Done  = (cyc == done_due) ||
                            ((it >= 23) && ($urandom_range(0, 19) == 0));
            bus.ADC_Value = DW'($urandom);

            #1;
            st = en && !r_now && ((en_cnt % HP) == ST);
            chk("ADC_Start", {31'd0, bus.ADC_Start}, {31'd0, st});
            if (st) done_due = cyc + $urandom_range(1, 3);

            // ---- advance the model across the coming edge ----
            if (r_now) begin
                if (q.size() > 0 && q[$].due >= cyc) void'(q.pop_back());
                model_reset();
            end else begin
                if (cap_now) begin
                    m_out[job_ch] = fir_fn(job_ch, job_din);
                    last          = job_ch;
                end
                if (cyc >= busy_until && pend != 2'b00) begin
                    dsel       = (pend == 2'b11) ? ~last : pend[1];
                    pend[dsel] = 1'b0;
                    has_job    = 1'b1;
                    job_ch     = dsel;
                    job_din    = slot[dsel];
                    job_dc     = cyc;
                    busy_until = cyc + 5;
                    fresh      = 1'b0;
                    q.push_back('{dsel, fir_fn(dsel, slot[dsel]), cyc + 4});
                end
                if (bus.ADC_Done && req_v) begin
                    if (pend[req_ch]) m_ovr = 1'b1;
                    slot[req_ch] = bus.ADC_Value;
                    pend[req_ch] = 1'b1;
                    req_v        = 1'b0;
                end
                if (en && ((en_cnt % HP) == HP - 1)) req_v = 1'b0;
                if (st) begin
                    req_v  = 1'b1;
                    req_ch = ((en_cnt / HP) % 2) == 1;
                end
                if (en) en_cnt++;
            end
        end

        @(negedge clk);
        chk("scoreboard_empty", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/fir_ppg_scheduler.md
Name: fir_ppg_scheduler

Overview:
- Sequences the pulse-oximeter front end: alternates the finger-clip LED between RED and IR, strobes the ADC after a settle time, and captures each sample.
- Shares one 3-phase FIR datapath (shift / multiply / add, one-hot enable) between the RED and IR channels.
- Presents filtered results per channel with valid pulses.
- Sits between the ADC interface and the downstream SpO2 logic.

Parameters:
- HALF_PERIOD, 500, CLK_Filter cycles per LED phase; 5 ms at 100 kHz gives 100 Hz alternation.
- SETTLE, 50, cycles after an LED toggle before ADC_Start is pulsed; legal range 1..HALF_PERIOD-2.
- DW, 8, ADC sample width.
- OW, 20, filter output width.

Ports:
- CLK_Filter  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Enable  in  1  run control.
- LED_Sel  out  1  0 = RED LED on, 1 = IR LED on.
- ADC_Start  out  1  one-cycle conversion request.
- ADC_Done  in  1  one-cycle conversion complete strobe.
- ADC_Value  in  DW  sample; valid only when ADC_Done = 1.
- Fir_Ch_Sel  out  1  FIR bank select; 0 = RED, 1 = IR.
- Fir_Din  out  DW  sample presented to the FIR; held constant through PH0..CAP.
- Fir_En  out  3  one-hot FIR phase enable: bit 0 shift, bit 1 multiply, bit 2 add.
- Fir_Dout  in  OW  FIR result.
- Out_RED_Filtered  out  OW  last RED result.
- Out_IR_Filtered  out  OW  last IR result.
- RED_Valid  out  1  one-cycle pulse on RED update.
- IR_Valid  out  1  one-cycle pulse on IR update.
- Overrun  out  1  sticky error flag; cleared only by rst.

Behaviour:
- Reset values (rst = 1 at a clock edge):
  - LED_Sel = 0, ADC_Start = 0, Fir_En = 000, Fir_Ch_Sel = 0, Fir_Din = 0.
  - Both outputs = 0, both valids = 0, Overrun = 0.
  - Phase counter = 0, pending flags cleared, FSM = IDLE, last-served = IR.
  - rst mid-job abandons the job with no valid pulse.
- Phase counter:
  - Counts 0..HALF_PERIOD-1 while Enable = 1.
  - On wrap to 0, LED_Sel toggles.
  - When count == SETTLE, ADC_Start = 1 for one cycle and the request channel latches LED_Sel.
  - Enable = 0: counter and LED_Sel freeze and no new ADC_Start is issued. An in-flight conversion and an in-flight FIR job still complete.
- Capture:
  - ADC_Done with an outstanding request stores ADC_Value into that channel's pending slot and sets its pending flag.
  - ADC_Done with no outstanding request is ignored.
  - No ADC_Done before the next LED toggle: the request is dropped silently.
  - ADC_Done into a slot whose pending flag is still set overwrites the sample and sets Overrun.
- Job FSM: IDLE -> PH0 -> PH1 -> PH2 -> CAP -> IDLE.
  - IDLE: if any pending flag is set, select a channel. With both pending, choose the channel not served last (round-robin). Register Fir_Ch_Sel and Fir_Din, clear that pending flag, go to PH0.
  - PH0: Fir_En = 001.
  - PH1: Fir_En = 010.
  - PH2: Fir_En = 100.
  - CAP: Fir_En = 000. Sample Fir_Dout into the selected channel's output, pulse its valid for one cycle, update last-served.
  - Latency: ADC_Done to valid pulse is 5 cycles when the FSM is idle (capture cycle, then IDLE, PH0, PH1, PH2, CAP).
- Simultaneous events:
  - ADC_Done in the same cycle IDLE clears a flag: the capture wins and the flag stays set with the new sample.
  - No job is lost except by overwrite, which sets Overrun.
- Fir_En is never multi-hot. Fir_Ch_Sel and Fir_Din are stable from PH0 through CAP.
- No arithmetic is performed on Fir_Dout; it is passed through at full OW width.

Test Plan:
- Reset/idle: rst for 3 cycles, Enable = 0 for 20 cycles -> all outputs 0, LED_Sel = 0, no ADC_Start.
- Alternation: HALF_PERIOD = 10, SETTLE = 3, Enable = 1 -> LED_Sel toggles every 10 cycles; ADC_Start at count 3 of each phase with the matching channel.
- Single job: ADC_Done with ADC_Value = 0x5A on the RED phase, Fir_Dout model returns 0x12345 -> Fir_En 001/010/100 on consecutive cycles; Out_RED_Filtered = 0x12345 with RED_Valid pulsed 5 cycles after ADC_Done; IR output unchanged.
- Round-robin: force both pending slots set, last-served = RED -> IR is served first, then RED; Fir_Din = 0x11 then 0x22.
- Overrun: two ADC_Done pulses for RED while the FSM is held busy -> second value overwrites the first, Overrun = 1 and stays 1 until rst.
- Reset mid-job: assert rst during PH1 -> next cycle Fir_En = 000, no valid pulse, FSM = IDLE.
